// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg : shared types and sizing helpers for the iterative divider   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package div_pkg;

  localparam int DIV_ITER_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int div_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fa_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fa_nbit : parametrised N-bit ripple-carry adder (sum and carry-out)   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fa_nbit #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic w_carry;

  always_comb begin
    o_sum   = '0;
    w_carry = i_cin;
    for (int i = 0; i < N; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry;
  end

endmodule
`default_nettype wire

// File: rtl/div_iter_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_iter_n : multi-cycle restoring divider, one quotient bit / clock  |
// | Optional two's-complement mode: define DIV_ITER_SIGNED_EN             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module div_iter_n
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW         = div_cnt_width(WIDTH);
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_zero;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_rem_step;
  logic             w_cout;
  logic [WIDTH-1:0] w_quo_step;
  logic [WIDTH-1:0] w_dvd_in;
  logic [WIDTH-1:0] w_dvs_in;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic [WIDTH-1:0] w_r_zero;
  logic             w_unused_rem_msb;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == C_CNT_ONE);

  assign w_rs = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};

  fa_nbit #(
    .N (WIDTH + 1)
  ) u_trial_sub (
    .i_a    (w_rs),
    .i_b    (~{1'b0, r_dvs}),
    .i_cin  (1'b1),
    .o_sum  (w_diff),
    .o_cout (w_cout)
  );

  assign w_rem_step = w_cout ? w_diff : w_rs;
  assign w_quo_step = {r_quo[WIDTH-2:0], w_cout};

  // The top bit of R only absorbs the trial-subtraction width; it is always 0 once stored.
  assign w_unused_rem_msb = r_rem[WIDTH];

`ifdef DIV_ITER_SIGNED_EN
  logic r_sq;
  logic r_sr;

  assign w_dvd_in = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvs_in = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_q_fin  = r_sq ? -w_quo_step : w_quo_step;
  assign w_r_fin  = r_sr ? -w_rem_step[WIDTH-1:0] : w_rem_step[WIDTH-1:0];
  assign w_r_zero = r_sr ? -r_quo : r_quo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sq <= 1'b0;
      r_sr <= 1'b0;
    end else if (w_accept) begin
      r_sq <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_sr <= dividend[WIDTH-1];
    end
  end
`else
  assign w_dvd_in = dividend;
  assign w_dvs_in = divisor;
  assign w_q_fin  = w_quo_step;
  assign w_r_fin  = w_rem_step[WIDTH-1:0];
  assign w_r_zero = r_quo;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == C_CNT_ONE) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A zero divisor spends a single frozen RUN cycle so done lands in cycle 3.
  // Results are written on the edge into FINISH so they are valid alongside done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_rem  <= '0;
      r_quo  <= w_dvd_in;
      r_dvs  <= w_dvs_in;
      r_zero <= (divisor == '0);
      r_cnt  <= (divisor == '0) ? C_CNT_ONE : C_CNT_LOAD;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt - C_CNT_ONE;
      if (!r_zero) begin
        r_rem <= w_rem_step;
        r_quo <= w_quo_step;
      end
      if (w_last) begin
        if (r_zero) begin
          r_quotient  <= '1;
          r_remainder <= w_r_zero;
          r_dbz       <= 1'b1;
        end else begin
          r_quotient  <= w_q_fin;
          r_remainder <= w_r_fin;
          r_dbz       <= 1'b0;
        end
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == FINISH);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
